// File: rtl/image_write.sv
// image_write: captures one RGB frame, two pixels per beat, into an internal
// byte buffer laid out in BMP order (bottom row first, B,G,R per pixel), then
// streams a complete 24-bit BMP file (54-byte header + pixel array) over a
// valid/ready byte interface.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSYNC                  beat valid; captures DATA_* while in CAPTURE
//   DATA_R0/G0/B0          even-column pixel components
//   DATA_R1/G1/B1          odd-column pixel components
//   out_ready              downstream accepts out_data this cycle
//   out_valid, out_data    BMP byte stream (out_data is 0 when not valid)
//   capture_done           one-cycle pulse after the last beat of a frame
//   tx_done                one-cycle pulse after the last file byte is taken
module image_write #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HSYNC,
  input  logic [7:0] DATA_R0,
  input  logic [7:0] DATA_G0,
  input  logic [7:0] DATA_B0,
  input  logic [7:0] DATA_R1,
  input  logic [7:0] DATA_G1,
  input  logic [7:0] DATA_B1,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       capture_done,
  output logic       tx_done
);

  localparam int IMG_BYTES  = WIDTH * HEIGHT * 3;
  localparam int FILE_BYTES = 54 + IMG_BYTES;
  localparam int IDX_W      = $clog2(FILE_BYTES + 1);
  localparam int MEM_AW     = $clog2(IMG_BYTES);
  localparam int COL_W      = $clog2(WIDTH);
  localparam int ROW_W      = $clog2(HEIGHT + 1);

  localparam logic [31:0] FILE_SIZE_W = 32'(FILE_BYTES);
  localparam logic [31:0] IMG_SIZE_W  = 32'(IMG_BYTES);
  localparam logic [31:0] WIDTH_W     = 32'(WIDTH);
  localparam logic [31:0] HEIGHT_W    = 32'(HEIGHT);

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_r;
  logic [COL_W-1:0]   col_r;
  logic [ROW_W-1:0]   row_r;
  logic [IDX_W-1:0]   idx_r;
  logic               capture_done_r;
  logic               tx_done_r;
  logic [7:0]         mem [IMG_BYTES];

  logic               col_last_s;
  logic               row_last_s;
  logic               hdr_last_s;
  logic               pay_last_s;
  logic               accept_s;
  logic [ROW_W-1:0]   row_inv_s;
  logic [MEM_AW-1:0]  wr_addr_s;

  // Header byte i of a 24-bit BMP. Every 32-bit field starts at an offset
  // that is 2 mod 4, so the byte lane inside the field is (i + 2) mod 4.
  function automatic logic [7:0] header_byte(input logic [5:0] i);
    logic [31:0] w;
    logic [1:0]  k;
    w = 32'd0;
    k = i[1:0] + 2'd2;
    case (i)
      6'd2,  6'd3,  6'd4,  6'd5:  w = FILE_SIZE_W;
      6'd10, 6'd11, 6'd12, 6'd13: w = 32'd54;
      6'd14, 6'd15, 6'd16, 6'd17: w = 32'd40;
      6'd18, 6'd19, 6'd20, 6'd21: w = WIDTH_W;
      6'd22, 6'd23, 6'd24, 6'd25: w = HEIGHT_W;
      6'd34, 6'd35, 6'd36, 6'd37: w = IMG_SIZE_W;
      default:                    w = 32'd0;
    endcase
    case (i)
      6'd0:    return 8'h42;
      6'd1:    return 8'h4D;
      6'd26:   return 8'h01;
      6'd28:   return 8'd24;
      default: return w[8*k +: 8];
    endcase
  endfunction

  assign col_last_s = (col_r == COL_W'(WIDTH - 2));
  assign row_last_s = (row_r == ROW_W'(HEIGHT - 1));
  assign hdr_last_s = (idx_r == IDX_W'(53));
  assign pay_last_s = (idx_r == IDX_W'(IMG_BYTES - 1));
  assign accept_s   = out_valid & out_ready;

  // Buffer base address of the current beat; input row 0 is the top row,
  // which BMP stores last.
  always_comb begin
    row_inv_s = ROW_W'(HEIGHT - 1) - row_r;
    wr_addr_s = MEM_AW'(WIDTH * 3) * MEM_AW'(row_inv_s) + MEM_AW'(3) * MEM_AW'(col_r);
  end

  // Frame buffer write: no reset, a new frame simply overwrites it.
  always_ff @(posedge HCLK) begin
    if (state_r == CAPTURE && HSYNC) begin
      mem[wr_addr_s]              <= DATA_B0;
      mem[wr_addr_s + MEM_AW'(1)] <= DATA_G0;
      mem[wr_addr_s + MEM_AW'(2)] <= DATA_R0;
      mem[wr_addr_s + MEM_AW'(3)] <= DATA_B1;
      mem[wr_addr_s + MEM_AW'(4)] <= DATA_G1;
      mem[wr_addr_s + MEM_AW'(5)] <= DATA_R1;
    end
  end

  // Control FSM: beat counters, byte index and the done pulses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r        <= CAPTURE;
      col_r          <= '0;
      row_r          <= '0;
      idx_r          <= '0;
      capture_done_r <= 1'b0;
      tx_done_r      <= 1'b0;
    end else begin
      capture_done_r <= 1'b0;
      tx_done_r      <= 1'b0;
      case (state_r)
        CAPTURE: begin
          if (HSYNC) begin
            if (col_last_s) begin
              col_r <= '0;
              if (row_last_s) begin
                row_r          <= '0;
                state_r        <= HEADER;
                capture_done_r <= 1'b1;
              end else begin
                row_r <= row_r + ROW_W'(1);
              end
            end else begin
              col_r <= col_r + COL_W'(2);
            end
          end
        end
        HEADER: begin
          if (out_ready) begin
            if (hdr_last_s) begin
              idx_r   <= '0;
              state_r <= PAYLOAD;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        PAYLOAD: begin
          if (out_ready) begin
            if (pay_last_s) begin
              idx_r     <= '0;
              state_r   <= DONE;
              tx_done_r <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        DONE: begin
          state_r <= CAPTURE;
        end
        default: begin
          state_r <= CAPTURE;
        end
      endcase
    end
  end

  assign out_valid    = (state_r == HEADER) || (state_r == PAYLOAD);
  assign capture_done = capture_done_r;
  assign tx_done      = tx_done_r;

  // Output byte selected from the header generator or the buffer.
  always_comb begin
    out_data = 8'h00;
    case (state_r)
      HEADER:  out_data = header_byte(idx_r[5:0]);
      PAYLOAD: out_data = mem[idx_r[MEM_AW-1:0]];
      default: out_data = 8'h00;
    endcase
  end

  // accept_s is kept for readability of the handshake; it mirrors the
  // condition the FSM uses when out_valid is implied by the state.
  logic unused_s;
  assign unused_s = accept_s;

endmodule

// File: tb/tb_image_write.sv
module tb_image_write;

  localparam int W = 4;
  localparam int H = 2;
  localparam int NFILE = 78;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       HSYNC = 1'b0;
  logic [7:0] DATA_R0 = 8'h00, DATA_G0 = 8'h00, DATA_B0 = 8'h00;
  logic [7:0] DATA_R1 = 8'h00, DATA_G1 = 8'h00, DATA_B1 = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       capture_done;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] r0, g0, b0, r1, g1, b1;
  } beat_t;

  beat_t      beats [4];
  logic [7:0] exp_file [NFILE];

  image_write #(.WIDTH(W), .HEIGHT(H)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .capture_done(capture_done), .tx_done(tx_done)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_data"}, 32'(out_data), 32'd0);
    chk({tag, " capture_done"}, 32'(capture_done), 32'd0);
    chk({tag, " tx_done"}, 32'(tx_done), 32'd0);
  endtask

  // Asynchronous reset pulse launched away from the clock edge.
  task automatic reset_pulse(input string tag);
    @(negedge HCLK);
    HSYNC = 1'b0;
    HRESETn = 1'b0;
    #1;
    check_reset_outputs(tag);
    #12;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  // Drive nbeats beats; gaps inserts an idle cycle between beats.
  task automatic send_frame(input bit gaps, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      HSYNC = 1'b1;
      DATA_R0 = beats[b].r0; DATA_G0 = beats[b].g0; DATA_B0 = beats[b].b0;
      DATA_R1 = beats[b].r1; DATA_G1 = beats[b].g1; DATA_B1 = beats[b].b1;
      @(posedge HCLK);
      #1;
      if (b < 3) begin
        chk("capture_done early", 32'(capture_done), 32'd0);
        chk("out_valid during capture", 32'(out_valid), 32'd0);
        if (gaps) begin
          HSYNC = 1'b0;
          DATA_R0 = 8'hEE;
          @(posedge HCLK);
          #1;
          chk("capture_done in gap", 32'(capture_done), 32'd0);
        end
      end else begin
        HSYNC = 1'b0;
        chk("capture_done pulse", 32'(capture_done), 32'd1);
        chk("out_valid after capture", 32'(out_valid), 32'd1);
      end
    end
    HSYNC = 1'b0;
  endtask

  // Receive the whole file, optional 5-cycle stall at byte stall_at, optional
  // random HSYNC/data noise, optional reset when byte reset_at is presented.
  task automatic receive(input int stall_at, input bit noise, input int reset_at);
    int  k;
    int  stall;
    int  cyc;
    bit  done;
    k = 0; stall = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      if (k == stall_at && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (noise) begin
        HSYNC = 1'($urandom);
        DATA_R0 = 8'($urandom); DATA_G0 = 8'($urandom); DATA_B0 = 8'($urandom);
        DATA_R1 = 8'($urandom); DATA_G1 = 8'($urandom); DATA_B1 = 8'($urandom);
      end
      @(negedge HCLK);
      if (k == reset_at) begin
        HSYNC = 1'b0;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("reset mid-payload");
        #12;
        HRESETn = 1'b1;
        out_ready = 1'b0;
        @(posedge HCLK);
        #1;
        return;
      end
      if (cyc == 1) chk("capture_done one cycle", 32'(capture_done), 32'd0);
      chk("out_valid streaming", 32'(out_valid), 32'd1);
      if (out_data !== exp_file[k])
        $display("  at file byte %0d", k);
      chk("out_data byte", 32'(out_data), 32'(exp_file[k]));
      if (out_ready) k++;
      if (k == NFILE) done = 1'b1;
      @(posedge HCLK);
      #1;
      cyc++;
    end
    HSYNC = 1'b0;
    out_ready = 1'b0;
    if (!done) begin
      chk("stream timeout bytes", 32'(k), 32'(NFILE));
      return;
    end
    @(negedge HCLK);
    chk("tx_done pulse", 32'(tx_done), 32'd1);
    chk("out_valid in DONE", 32'(out_valid), 32'd0);
    chk("out_data in DONE", 32'(out_data), 32'd0);
    @(posedge HCLK);
    #1;
    @(negedge HCLK);
    chk("tx_done one cycle", 32'(tx_done), 32'd0);
    chk("out_valid back in CAPTURE", 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Pixel n: R=0x10+n, G=0x20+n, B=0x30+n; beat b carries pixels 2b, 2b+1.
    beats[0] = '{r0: 8'h10, g0: 8'h20, b0: 8'h30, r1: 8'h11, g1: 8'h21, b1: 8'h31};
    beats[1] = '{r0: 8'h12, g0: 8'h22, b0: 8'h32, r1: 8'h13, g1: 8'h23, b1: 8'h33};
    beats[2] = '{r0: 8'h14, g0: 8'h24, b0: 8'h34, r1: 8'h15, g1: 8'h25, b1: 8'h35};
    beats[3] = '{r0: 8'h16, g0: 8'h26, b0: 8'h36, r1: 8'h17, g1: 8'h27, b1: 8'h37};

    exp_file = '{
      8'h42, 8'h4D, 8'h4E, 8'h00, 8'h00, 8'h00,             // magic, file size 78
      8'h00, 8'h00, 8'h00, 8'h00,                           // reserved
      8'h36, 8'h00, 8'h00, 8'h00,                           // offset 54
      8'h28, 8'h00, 8'h00, 8'h00,                           // DIB size 40
      8'h04, 8'h00, 8'h00, 8'h00,                           // width 4
      8'h02, 8'h00, 8'h00, 8'h00,                           // height 2
      8'h01, 8'h00, 8'h18, 8'h00,                           // planes, bpp 24
      8'h00, 8'h00, 8'h00, 8'h00,                           // compression
      8'h18, 8'h00, 8'h00, 8'h00,                           // image size 24
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h34, 8'h24, 8'h14, 8'h35, 8'h25, 8'h15,             // bottom row = input row 1
      8'h36, 8'h26, 8'h16, 8'h37, 8'h27, 8'h17,
      8'h30, 8'h20, 8'h10, 8'h31, 8'h21, 8'h11,             // top row = input row 0
      8'h32, 8'h22, 8'h12, 8'h33, 8'h23, 8'h13
    };

    // Reset state.
    #12;
    check_reset_outputs("in reset");
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    @(posedge HCLK);
    #1;
    chk("idle out_valid", 32'(out_valid), 32'd0);
    chk("idle capture_done", 32'(capture_done), 32'd0);

    // Back-to-back frame, stall of 5 cycles on header byte 2.
    send_frame(1'b0, 4);
    receive(2, 1'b0, -1);

    // Gapped capture, random HSYNC/data noise during transmission.
    send_frame(1'b1, 4);
    receive(-1, 1'b1, -1);

    // Reset at payload byte 10, then a fresh frame.
    send_frame(1'b0, 4);
    receive(-1, 1'b0, 54 + 10);
    send_frame(1'b0, 4);
    receive(-1, 1'b0, -1);

    // Reset mid-capture: counters must restart at row 0, col 0.
    send_frame(1'b0, 2);
    reset_pulse("reset mid-capture");
    send_frame(1'b0, 4);
    receive(-1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_write.md
IMAGE_WRITE -- requirements
Module: image_write

Interface
REQ-001 Parameter WIDTH, default 768, image width in pixels; SHALL be even and WIDTH*3 SHALL be a multiple of 4 (no row padding).
REQ-002 Parameter HEIGHT, default 512, image height in pixels.
REQ-003 HCLK  input  1  clock; all state updates on rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 HSYNC  input  1  beat valid; when high, the 2-pixel beat on DATA_* is captured.
REQ-006 DATA_R0, DATA_G0, DATA_B0  input  8 each  even-pixel (col) colour components.
REQ-007 DATA_R1, DATA_G1, DATA_B1  input  8 each  odd-pixel (col+1) colour components.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid BMP file byte.
REQ-010 out_data  output  8  BMP file byte stream (header, then pixel array).
REQ-011 capture_done  output  1  one-cycle pulse, full frame captured.
REQ-012 tx_done  output  1  one-cycle pulse, final file byte accepted.

Function
REQ-013 Internal byte buffer of WIDTH*HEIGHT*3 bytes holding the pixel array in BMP order.
REQ-014 FSM states: CAPTURE, HEADER, PAYLOAD, DONE; state SHALL be CAPTURE after reset.
REQ-015 CAPTURE: each cycle with HSYNC=1 writes 6 bytes at A=WIDTH*3*(HEIGHT-1-row)+3*col: A+0=B0, A+1=G0, A+2=R0, A+3=B1, A+4=G1, A+5=R1.
REQ-016 Beat counters: col steps by 2 per accepted beat; at col=WIDTH-2, col wraps to 0 and row increments; HSYNC=0 holds col/row (gaps allowed).
REQ-017 On the beat where row=HEIGHT-1 and col=WIDTH-2: next state HEADER, capture_done=1 for the following cycle only, col/row cleared to 0.
REQ-018 HEADER/PAYLOAD/DONE: HSYNC and DATA_* SHALL be ignored; buffer not written.
REQ-019 out_valid SHALL be 1 exactly in HEADER and PAYLOAD; out_data SHALL be 0 when out_valid=0.
REQ-020 Byte index increments only when out_valid and out_ready both 1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 HEADER emits 54 bytes, index 0..53, multi-byte fields little-endian: 0-1 "BM" (0x42,0x4D); 2-5 file size 54+WIDTH*HEIGHT*3; 6-9 zero; 10-13 offset 54; 14-17 DIB size 40; 18-21 WIDTH; 22-25 HEIGHT; 26-27 planes 1; 28-29 bpp 24; 30-33 compression 0; 34-37 image size WIDTH*HEIGHT*3; 38-53 zero.
REQ-022 Acceptance of header byte 53 moves to PAYLOAD with payload index 0.
REQ-023 PAYLOAD emits buffer bytes 0..WIDTH*HEIGHT*3-1 in address order; out_data is combinational from the current index.
REQ-024 Acceptance of the last payload byte moves to DONE; DONE lasts one cycle with tx_done=1, out_valid=0, then returns to CAPTURE with all counters 0.
REQ-025 Byte/beat counters SHALL be wide enough for 54+WIDTH*HEIGHT*3 without wrap; arithmetic unsigned.

Reset
REQ-026 HRESETn=0 at any time, including mid-capture or mid-transmission, SHALL immediately force state CAPTURE, col=row=0, byte index 0, out_valid=0, out_data=0, capture_done=0, tx_done=0.
REQ-027 Buffer contents SHALL NOT be cleared by reset; a new frame overwrites them.

Verification (WIDTH=4, HEIGHT=2 unless stated)
REQ-028 4 back-to-back HSYNC beats, pixel n (0..7) = R=0x10+n, G=0x20+n, B=0x30+n -> capture_done pulse 1 cycle after beat 4; out_valid high next cycle; bytes 0..2 = 0x42,0x4D,0x4E; byte 18 = 0x04, byte 22 = 0x02.
REQ-029 Same frame, out_ready=1 -> payload bytes 0..5 = 0x34,0x24,0x14,0x35,0x25,0x15 (bottom row = input row 1); bytes 12..17 = 0x30,0x20,0x10,0x31,0x21,0x11; tx_done 1 cycle after byte 77 accepted.
REQ-030 HSYNC toggling 1/0 per cycle during capture -> identical buffer/stream to REQ-029; capture_done after 8 cycles.
REQ-031 out_ready=0 for 5 cycles at header byte 2 -> out_data held 0x4E, out_valid held 1, index unchanged; resumes with byte 3 = 0x00.
REQ-032 HSYNC=1 with random data throughout HEADER/PAYLOAD -> payload unchanged from REQ-029.
REQ-033 HRESETn pulsed low at payload byte 10, then new frame -> out_valid=0 immediately; next capture restarts at row 0 col 0; full correct file transmitted.
